// File: rtl/tl_txn_tracker_if.sv
// A/D channel signals observed by the transaction tracker. The tracker is a
// passive monitor: the master side drives everything, the slave side only samples.
interface tl_txn_tracker_if #(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 2,
    parameter int SIZE_W = 4
);
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic              d_denied;
    logic              d_corrupt;

    modport master (
        output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        output d_valid, d_ready, d_opcode, d_size, d_source, d_denied, d_corrupt
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        input d_valid, d_ready, d_opcode, d_size, d_source, d_denied, d_corrupt
    );
endinterface

// File: rtl/tl_txn_tracker.sv
// Per-source request/response tracker: counts transactions, measures latency and
// flags duplicate, orphan, timed-out and denied/corrupt transactions.
module tl_txn_tracker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 2,
    parameter int SIZE_W  = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    tl_txn_tracker_if.slave      bus,
    output logic [SRC_W:0]       outstanding,
    output logic [CNT_W-1:0]     req_count,
    output logic [CNT_W-1:0]     rsp_count,
    output logic [CNT_W-1:0]     max_latency,
    output logic [3:0]           err_flags,
    output logic                 err_pulse,
    output logic [SRC_W-1:0]     err_source,
    output logic [ADDR_W-1:0]    err_address
);
    localparam int NSRC      = 1 << SRC_W;
    localparam int LOG_BYTES = $clog2(DATA_W / 8);

    function automatic logic [31:0] beat_count(input logic multi, input logic [SIZE_W-1:0] size);
        int sz;
        sz = int'(size);
        if (multi && sz > LOG_BYTES) return 32'd1 << (sz - LOG_BYTES);
        return 32'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic              a_fire, d_fire, a_first, a_last, d_first, d_last;
    logic              a_busy_eff, a_alloc, a_dup, a_ok, req_inc;
    logic              d_orphan, d_free, e_den, e_to, err_any;
    logic [31:0]       a_beats, d_beats;
    logic [31:0]       a_beat_q, a_beat_d, d_beat_q, d_beat_d;
    logic              a_ok_q, a_ok_d, d_orph_q, d_orph_d;
    logic [NSRC-1:0]   busy_q, busy_d, to_hit;
    logic [ADDR_W-1:0] addr_q [NSRC];
    logic [ADDR_W-1:0] addr_d [NSRC];
    logic [CNT_W-1:0]  timer_q [NSRC];
    logic [CNT_W-1:0]  timer_d [NSRC];
    logic [CNT_W-1:0]  lat;
    logic [SRC_W:0]    outst_d, outst_q;
    logic [SRC_W-1:0]  esrc_d, esrc_q;
    logic [ADDR_W-1:0] eaddr_d, eaddr_q;
    logic [CNT_W-1:0]  req_q, rsp_q, maxlat_q;
    logic [3:0]        eflags_q;
    logic              epulse_q;

    always_comb begin
        a_fire  = bus.a_valid & bus.a_ready & enable;
        d_fire  = bus.d_valid & bus.d_ready & enable;
        a_beats = beat_count(bus.a_opcode <= 3'd3, bus.a_size);
        d_beats = beat_count((bus.d_opcode == 3'd1) || (bus.d_opcode == 3'd5), bus.d_size);
        a_first = (a_beat_q == 32'd0);
        a_last  = (a_beat_q >= a_beats - 32'd1);
        d_first = (d_beat_q == 32'd0);
        d_last  = (d_beat_q >= d_beats - 32'd1);

        a_beat_d = a_beat_q;
        if (a_fire) a_beat_d = a_last ? 32'd0 : a_beat_q + 32'd1;
        d_beat_d = d_beat_q;
        if (d_fire) d_beat_d = d_last ? 32'd0 : d_beat_q + 32'd1;

        // An orphan burst stays an orphan to its last beat, even if the slot
        // gets allocated mid-burst.
        d_orphan = d_fire & d_first & ~busy_q[bus.d_source];
        d_free   = d_fire & d_last & busy_q[bus.d_source] & (d_first | ~d_orph_q);
        d_orph_d = d_orph_q;
        if (d_fire) d_orph_d = d_last ? 1'b0 : (d_first ? d_orphan : d_orph_q);

        a_busy_eff = busy_q[bus.a_source] & ~(d_free & (bus.d_source == bus.a_source));
        a_alloc    = a_fire & a_first & ~a_busy_eff;
        a_dup      = a_fire & a_first & a_busy_eff;
        a_ok       = a_first ? ~a_busy_eff : a_ok_q;
        req_inc    = a_fire & a_last & a_ok;
        a_ok_d     = a_ok_q;
        if (a_fire) a_ok_d = a_last ? 1'b0 : a_ok;

        lat   = timer_q[bus.d_source] + CNT_W'(1);
        e_den = d_fire & (bus.d_denied | bus.d_corrupt);

        busy_d  = busy_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        to_hit  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (enable && busy_q[i] && timer_q[i] != CNT_W'(TIMEOUT)) begin
                timer_d[i] = timer_q[i] + CNT_W'(1);
                to_hit[i]  = (timer_q[i] == CNT_W'(TIMEOUT - 1)) &
                             ~(d_free & (bus.d_source == SRC_W'(i)));
            end
        end
        if (d_free) busy_d[bus.d_source] = 1'b0;
        if (a_alloc) begin
            busy_d[bus.a_source]  = 1'b1;
            addr_d[bus.a_source]  = bus.a_address;
            timer_d[bus.a_source] = '0;
        end

        e_to    = |to_hit;
        err_any = d_orphan | a_dup | e_den | e_to;

        outst_d = '0;
        for (int i = 0; i < NSRC; i++) outst_d = outst_d + (SRC_W + 1)'(busy_d[i]);

        // Later assignments win: lowest timed-out slot, then denied, duplicate, orphan.
        esrc_d  = '0;
        eaddr_d = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (to_hit[i]) begin
                esrc_d  = SRC_W'(i);
                eaddr_d = addr_q[i];
            end
        end
        if (e_den) begin
            esrc_d  = bus.d_source;
            eaddr_d = busy_q[bus.d_source] ? addr_q[bus.d_source] : '0;
        end
        if (a_dup) begin
            esrc_d  = bus.a_source;
            eaddr_d = addr_q[bus.a_source];
        end
        if (d_orphan) begin
            esrc_d  = bus.d_source;
            eaddr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= '0;
            a_beat_q <= '0;
            d_beat_q <= '0;
            a_ok_q   <= 1'b0;
            d_orph_q <= 1'b0;
            for (int i = 0; i < NSRC; i++) timer_q[i] <= '0;
            outst_q  <= '0;
            req_q    <= '0;
            rsp_q    <= '0;
            maxlat_q <= '0;
            eflags_q <= '0;
            epulse_q <= 1'b0;
            esrc_q   <= '0;
            eaddr_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            timer_q  <= timer_d;
            a_beat_q <= a_beat_d;
            d_beat_q <= d_beat_d;
            a_ok_q   <= a_ok_d;
            d_orph_q <= d_orph_d;
            outst_q  <= outst_d;
            if (clear) begin
                req_q    <= '0;
                rsp_q    <= '0;
                maxlat_q <= '0;
                eflags_q <= '0;
                epulse_q <= 1'b0;
                esrc_q   <= '0;
                eaddr_q  <= '0;
            end else begin
                if (req_inc) req_q <= sat_inc(req_q);
                if (d_free) begin
                    rsp_q    <= sat_inc(rsp_q);
                    maxlat_q <= max_cnt(maxlat_q, lat);
                end
                eflags_q <= eflags_q | {e_den, e_to, d_orphan, a_dup};
                epulse_q <= err_any;
                if (err_any) begin
                    esrc_q  <= esrc_d;
                    eaddr_q <= eaddr_d;
                end
            end
        end
    end

    assign outstanding = outst_q;
    assign req_count   = req_q;
    assign rsp_count   = rsp_q;
    assign max_latency = maxlat_q;
    assign err_flags   = eflags_q;
    assign err_pulse   = epulse_q;
    assign err_source  = esrc_q;
    assign err_address = eaddr_q;
endmodule
